// File: rtl/lock_access_ctrl.sv
// Keypad lock controller: collects a multi-digit code, compares it with a
// reprogrammable stored code, drives timed unlock/alarm and a failure lockout.
module lock_access_ctrl #(
  parameter int DIGIT_W     = 4,
  parameter int CODE_LEN    = 4,
  parameter int MAX_FAILS   = 3,
  parameter int UNLOCK_CYC  = 50,
  parameter int LOCKOUT_CYC = 200,
  parameter logic [DIGIT_W*CODE_LEN-1:0] DEFAULT_CODE = 16'h1234
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             key_valid,
  input  logic [DIGIT_W-1:0]               key_digit,
  input  logic                             key_enter,
  input  logic                             key_clear,
  input  logic                             prog_we,
  input  logic [DIGIT_W*CODE_LEN-1:0]      prog_code,
  output logic                             unlock,
  output logic                             alarm,
  output logic                             fail_pulse,
  output logic                             prog_ack,
  output logic [$clog2(MAX_FAILS+1)-1:0]   fail_cnt
);

  localparam int CODE_W = DIGIT_W * CODE_LEN;
  localparam int CNT_W  = $clog2(CODE_LEN + 1);
  localparam int FAIL_W = $clog2(MAX_FAILS + 1);
  localparam int MAXCYC = (UNLOCK_CYC > LOCKOUT_CYC) ? UNLOCK_CYC : LOCKOUT_CYC;
  localparam int TMR_W  = $clog2(MAXCYC + 1);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_ENTRY   = 3'd1;
  localparam logic [2:0] S_CHECK   = 3'd2;
  localparam logic [2:0] S_OPEN    = 3'd3;
  localparam logic [2:0] S_LOCKOUT = 3'd4;

  logic [2:0]        state_q, state_d;
  logic [CODE_W-1:0] entry_q, entry_d;
  logic [CODE_W-1:0] stored_q, stored_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              ovf_q, ovf_d;
  logic [TMR_W-1:0]  timer_q, timer_d;
  logic [FAIL_W-1:0] fail_cnt_q, fail_cnt_d;
  logic              unlock_q, unlock_d;
  logic              alarm_q, alarm_d;
  logic              fail_pulse_q, fail_pulse_d;
  logic              prog_ack_q, prog_ack_d;
  logic              match;

  assign match = (count_q == CNT_W'(CODE_LEN)) && !ovf_q && (entry_q == stored_q);

  always_comb begin
    state_d      = state_q;
    entry_d      = entry_q;
    stored_d     = stored_q;
    count_d      = count_q;
    ovf_d        = ovf_q;
    timer_d      = timer_q;
    fail_cnt_d   = fail_cnt_q;
    unlock_d     = unlock_q;
    alarm_d      = alarm_q;
    fail_pulse_d = 1'b0;
    prog_ack_d   = 1'b0;

    case (state_q)
      S_IDLE, S_ENTRY: begin
        if (key_clear) begin
          entry_d = '0;
          count_d = '0;
          ovf_d   = 1'b0;
          state_d = S_IDLE;
        end else if (key_enter) begin
          state_d = S_CHECK;
        end else if (key_valid) begin
          entry_d = (entry_q << DIGIT_W) | CODE_W'(key_digit);
          // count saturates; any further digit marks the entry as overlong
          if (count_q == CNT_W'(CODE_LEN)) ovf_d = 1'b1;
          else count_d = count_q + 1'b1;
          state_d = S_ENTRY;
        end
      end
      S_CHECK: begin
        entry_d = '0;
        count_d = '0;
        ovf_d   = 1'b0;
        if (match) begin
          state_d    = S_OPEN;
          unlock_d   = 1'b1;
          fail_cnt_d = '0;
          timer_d    = TMR_W'(UNLOCK_CYC - 1);
        end else begin
          fail_pulse_d = 1'b1;
          if (fail_cnt_q == FAIL_W'(MAX_FAILS - 1)) begin
            state_d    = S_LOCKOUT;
            alarm_d    = 1'b1;
            timer_d    = TMR_W'(LOCKOUT_CYC - 1);
            fail_cnt_d = FAIL_W'(MAX_FAILS);
          end else begin
            fail_cnt_d = fail_cnt_q + 1'b1;
            state_d    = S_IDLE;
          end
        end
      end
      S_OPEN: begin
        if (prog_we) begin
          stored_d   = prog_code;
          prog_ack_d = 1'b1;
        end
        if (timer_q == '0) begin
          state_d  = S_IDLE;
          unlock_d = 1'b0;
        end else begin
          timer_d = timer_q - 1'b1;
        end
      end
      S_LOCKOUT: begin
        if (timer_q == '0) begin
          state_d    = S_IDLE;
          alarm_d    = 1'b0;
          fail_cnt_d = '0;
        end else begin
          timer_d = timer_q - 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= S_IDLE;
      entry_q      <= '0;
      stored_q     <= DEFAULT_CODE;
      count_q      <= '0;
      ovf_q        <= 1'b0;
      timer_q      <= '0;
      fail_cnt_q   <= '0;
      unlock_q     <= 1'b0;
      alarm_q      <= 1'b0;
      fail_pulse_q <= 1'b0;
      prog_ack_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      entry_q      <= entry_d;
      stored_q     <= stored_d;
      count_q      <= count_d;
      ovf_q        <= ovf_d;
      timer_q      <= timer_d;
      fail_cnt_q   <= fail_cnt_d;
      unlock_q     <= unlock_d;
      alarm_q      <= alarm_d;
      fail_pulse_q <= fail_pulse_d;
      prog_ack_q   <= prog_ack_d;
    end
  end

  assign unlock     = unlock_q;
  assign alarm      = alarm_q;
  assign fail_pulse = fail_pulse_q;
  assign prog_ack   = prog_ack_q;
  assign fail_cnt   = fail_cnt_q;

endmodule

// File: tb/tb_lock_access_ctrl.sv
// Directed bench for lock_access_ctrl: a per-cycle vector table followed by
// hand-written sequences for the timed unlock/lockout, programming and reset.
module tb_lock_access_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        key_valid, key_enter, key_clear, prog_we;
  logic [3:0]  key_digit;
  logic [15:0] prog_code;
  logic        unlock, alarm, fail_pulse, prog_ack;
  logic [1:0]  fail_cnt;

  int errors = 0;
  int checks = 0;
  int unl_cnt = 0;
  int alm_cnt = 0;

  always #5 clk = ~clk;

  lock_access_ctrl #(
    .DIGIT_W(4), .CODE_LEN(4), .MAX_FAILS(3),
    .UNLOCK_CYC(50), .LOCKOUT_CYC(200), .DEFAULT_CODE(16'h1234)
  ) dut (
    .clk(clk), .reset(reset),
    .key_valid(key_valid), .key_digit(key_digit),
    .key_enter(key_enter), .key_clear(key_clear),
    .prog_we(prog_we), .prog_code(prog_code),
    .unlock(unlock), .alarm(alarm), .fail_pulse(fail_pulse),
    .prog_ack(prog_ack), .fail_cnt(fail_cnt)
  );

  typedef struct {
    logic        vld;
    logic [3:0]  dig;
    logic        ent;
    logic        clr;
    logic        pw;
    logic [15:0] pc;
    logic        e_unl;
    logic        e_alm;
    logic        e_fp;
    logic        e_ack;
    logic [1:0]  e_fc;
  } vec_t;

  vec_t tbl[$];

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    if (unlock) unl_cnt++;
    if (alarm) alm_cnt++;
    chk("unlock_alarm_exclusive", int'(unlock & alarm), 0);
  endtask

  task automatic cyc(input logic vld, input logic [3:0] dig, input logic ent,
                     input logic clr, input logic pw, input logic [15:0] pc);
    key_valid = vld; key_digit = dig; key_enter = ent; key_clear = clr;
    prog_we = pw; prog_code = pc;
    tick();
    key_valid = 0; key_digit = 0; key_enter = 0; key_clear = 0; prog_we = 0;
  endtask

  task automatic key(input logic [3:0] d);
    cyc(1, d, 0, 0, 0, 16'h0);
  endtask

  task automatic enter();
    cyc(0, 0, 1, 0, 0, 16'h0);
  endtask

  task automatic code_enter(input logic [15:0] c);
    key(c[15:12]); key(c[11:8]); key(c[7:4]); key(c[3:0]);
    enter();
  endtask

  // Tick until both unlock and alarm are low, bounded.
  task automatic wait_low();
    for (int i = 0; i < 1000 && (unlock || alarm); i++) tick();
    chk("wait_low_timeout", int'(unlock | alarm), 0);
  endtask

  task automatic add(input logic vld, input logic [3:0] dig, input logic ent,
                     input logic clr, input logic pw, input logic [15:0] pc,
                     input logic u, input logic a, input logic fp,
                     input logic ack, input logic [1:0] fc);
    vec_t v;
    v.vld = vld; v.dig = dig; v.ent = ent; v.clr = clr; v.pw = pw; v.pc = pc;
    v.e_unl = u; v.e_alm = a; v.e_fp = fp; v.e_ack = ack; v.e_fc = fc;
    tbl.push_back(v);
  endtask

  initial begin
    // vld dig ent clr pw pc       | unl alm fp ack fc
    add(1, 1, 0, 0, 0, 16'h0,       0, 0, 0, 0, 0);
    add(1, 2, 0, 0, 0, 16'h0,       0, 0, 0, 0, 0);
    add(1, 3, 0, 0, 0, 16'h0,       0, 0, 0, 0, 0);
    add(1, 5, 0, 0, 0, 16'h0,       0, 0, 0, 0, 0);
    add(0, 0, 1, 0, 0, 16'h0,       0, 0, 0, 0, 0);
    add(0, 0, 0, 0, 0, 16'h0,       0, 0, 1, 0, 1);
    add(0, 0, 0, 0, 0, 16'h0,       0, 0, 0, 0, 1);
    add(0, 0, 1, 0, 0, 16'h0,       0, 0, 0, 0, 1);
    add(0, 0, 0, 0, 0, 16'h0,       0, 0, 1, 0, 2);
    add(0, 0, 0, 0, 0, 16'h0,       0, 0, 0, 0, 2);
    add(1, 1, 1, 1, 0, 16'h0,       0, 0, 0, 0, 2);
    add(0, 0, 0, 0, 1, 16'hABCD,    0, 0, 0, 0, 2);
    add(1, 1, 0, 0, 0, 16'h0,       0, 0, 0, 0, 2);
    add(1, 2, 0, 0, 0, 16'h0,       0, 0, 0, 0, 2);
    add(1, 3, 0, 0, 0, 16'h0,       0, 0, 0, 0, 2);
    add(1, 4, 0, 0, 0, 16'h0,       0, 0, 0, 0, 2);
    add(1, 4, 0, 0, 0, 16'h0,       0, 0, 0, 0, 2);
    add(0, 0, 1, 0, 0, 16'h0,       0, 0, 0, 0, 2);
    add(0, 0, 0, 0, 0, 16'h0,       0, 1, 1, 0, 3);

    reset = 1; key_valid = 0; key_digit = 0; key_enter = 0; key_clear = 0;
    prog_we = 0; prog_code = 0;
    @(posedge clk); @(posedge clk); #1;
    reset = 0;
    chk("rst_unlock", int'(unlock), 0);
    chk("rst_alarm", int'(alarm), 0);
    chk("rst_fail_pulse", int'(fail_pulse), 0);
    chk("rst_prog_ack", int'(prog_ack), 0);
    chk("rst_fail_cnt", int'(fail_cnt), 0);

    unl_cnt = 0; alm_cnt = 0;
    foreach (tbl[i]) begin
      cyc(tbl[i].vld, tbl[i].dig, tbl[i].ent, tbl[i].clr, tbl[i].pw, tbl[i].pc);
      chk($sformatf("v%0d_unlock", i), int'(unlock), int'(tbl[i].e_unl));
      chk($sformatf("v%0d_alarm", i), int'(alarm), int'(tbl[i].e_alm));
      chk($sformatf("v%0d_fail_pulse", i), int'(fail_pulse), int'(tbl[i].e_fp));
      chk($sformatf("v%0d_prog_ack", i), int'(prog_ack), int'(tbl[i].e_ack));
      chk($sformatf("v%0d_fail_cnt", i), int'(fail_cnt), int'(tbl[i].e_fc));
    end

    // Lockout: keys ignored, alarm lasts exactly 200 cycles, then count clears.
    for (int i = 0; i < 4; i++) begin
      key(4'h9);
      chk("lockout_alarm_held", int'(alarm), 1);
    end
    enter();
    tick();
    chk("lockout_no_fail_pulse", int'(fail_pulse), 0);
    wait_low();
    chk("lockout_alarm_cycles", alm_cnt, 200);
    chk("lockout_fail_cnt_cleared", int'(fail_cnt), 0);

    // Clear discards partial entry; default code still valid after IDLE prog_we.
    key(1); key(2);
    cyc(0, 0, 0, 1, 0, 16'h0);
    unl_cnt = 0;
    code_enter(16'h1234);
    chk("open_latency_unlock_low", int'(unlock), 0);
    tick();
    chk("open_unlock", int'(unlock), 1);
    chk("open_fail_cnt", int'(fail_cnt), 0);
    chk("open_alarm", int'(alarm), 0);
    cyc(0, 0, 0, 0, 1, 16'hABCD);
    chk("prog_ack_high", int'(prog_ack), 1);
    tick();
    chk("prog_ack_pulse", int'(prog_ack), 0);
    wait_low();
    chk("unlock_cycles", unl_cnt, 50);

    // New code active: old one fails, new one opens.
    code_enter(16'h1234);
    tick();
    chk("old_code_fail_pulse", int'(fail_pulse), 1);
    chk("old_code_fail_cnt", int'(fail_cnt), 1);
    chk("old_code_unlock", int'(unlock), 0);
    code_enter(16'hABCD);
    tick();
    chk("new_code_unlock", int'(unlock), 1);
    chk("new_code_fail_cnt", int'(fail_cnt), 0);

    // Reset mid-OPEN aborts and restores the default code.
    tick(); tick();
    reset = 1;
    tick();
    reset = 0;
    chk("rst_open_unlock", int'(unlock), 0);
    chk("rst_open_fail_cnt", int'(fail_cnt), 0);
    code_enter(16'h1234);
    tick();
    chk("rst_open_default_code", int'(unlock), 1);
    wait_low();

    // Reset mid-LOCKOUT.
    for (int i = 0; i < 3; i++) begin
      enter();
      tick();
    end
    chk("lock2_alarm", int'(alarm), 1);
    chk("lock2_fail_cnt", int'(fail_cnt), 3);
    for (int i = 0; i < 5; i++) tick();
    reset = 1;
    tick();
    reset = 0;
    chk("rst_lock_alarm", int'(alarm), 0);
    chk("rst_lock_fail_cnt", int'(fail_cnt), 0);
    code_enter(16'h1234);
    tick();
    chk("rst_lock_unlock", int'(unlock), 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
